// File: rtl/aa_reorder_buffer.sv
// Antialias-to-IMDCT reorder buffer: two ping-pong granule banks,
// pair-beat fill by sample index, sequential subband-major drain.
module aa_reorder_buffer #(
    parameter int DATA_W = 32,
    parameter int GR_LEN = 576,
    parameter int BEATS  = 288
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ch1_in_x,
    input  logic [DATA_W-1:0] ch1_in_y,
    input  logic [DATA_W-1:0] ch2_in_x,
    input  logic [DATA_W-1:0] ch2_in_y,
    input  logic [9:0]        is_pos_in_x,
    input  logic [9:0]        is_pos_in_y,
    input  logic              din_v,
    input  logic [1:0][1:0]   block_type_in,
    output logic [DATA_W-1:0] ch1_out,
    output logic [DATA_W-1:0] ch2_out,
    output logic [4:0]        sb_out,
    output logic [4:0]        ss_out,
    output logic [1:0][1:0]   block_type_out,
    output logic              dout_v,
    input  logic              dout_ready,
    output logic              gr_last,
    output logic              err_range,
    output logic              err_overflow
);

    localparam int CW = $clog2(BEATS);
    localparam logic [9:0]    LEN_A  = 10'(GR_LEN);
    localparam logic [9:0]    LAST_A = 10'(GR_LEN - 1);
    localparam logic [CW-1:0] LAST_C = CW'(BEATS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [2*DATA_W-1:0] mem_a [GR_LEN];
    logic [2*DATA_W-1:0] mem_b [GR_LEN];

    logic [1:0]           full_q, full_d;
    logic                 fptr_q, fptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0][1:0][1:0] bt_q, bt_d;
    logic [0:0]           state_q, state_d;
    logic                 dbank_q, dbank_d;
    logic [9:0]           rd_idx_q, rd_idx_d;
    logic [4:0]           ld_sb_q, ld_sb_d;
    logic [4:0]           ld_ss_q, ld_ss_d;
    logic [DATA_W-1:0]    ch1_q, ch1_d;
    logic [DATA_W-1:0]    ch2_q, ch2_d;
    logic [4:0]           sb_q, sb_d;
    logic [4:0]           ss_q, ss_d;
    logic [1:0][1:0]      bto_q, bto_d;
    logic                 vld_q, vld_d;
    logic                 last_q, last_d;
    logic                 rng_q, rng_d;
    logic                 ovf_q, ovf_d;

    logic                 fill_ok;
    logic                 wr_x;
    logic                 wr_y;
    logic [9:0]           rd_addr;
    logic [2*DATA_W-1:0]  rd_word;

    assign fill_ok = din_v && !full_q[fptr_q];
    assign wr_y    = fill_ok && (is_pos_in_y < LEN_A);
    // x write yields to y when both target the same index
    assign wr_x    = fill_ok && (is_pos_in_x < LEN_A)
                     && (is_pos_in_x != is_pos_in_y);
    assign rd_addr = (rd_idx_q < LEN_A) ? rd_idx_q : '0;
    assign rd_word = dbank_q ? mem_b[rd_addr] : mem_a[rd_addr];

    // Bank storage: two writes per beat into the filling bank
    always_ff @(posedge clk) begin
        if (wr_x && !fptr_q) mem_a[is_pos_in_x] <= {ch1_in_x, ch2_in_x};
        if (wr_x &&  fptr_q) mem_b[is_pos_in_x] <= {ch1_in_x, ch2_in_x};
        if (wr_y && !fptr_q) mem_a[is_pos_in_y] <= {ch1_in_y, ch2_in_y};
        if (wr_y &&  fptr_q) mem_b[is_pos_in_y] <= {ch1_in_y, ch2_in_y};
    end

    // Next-state: fill bookkeeping, drain FSM and output register
    always_comb begin
        full_d   = full_q;
        fptr_d   = fptr_q;
        cnt_d    = cnt_q;
        bt_d     = bt_q;
        state_d  = state_q;
        dbank_d  = dbank_q;
        rd_idx_d = rd_idx_q;
        ld_sb_d  = ld_sb_q;
        ld_ss_d  = ld_ss_q;
        ch1_d    = ch1_q;
        ch2_d    = ch2_q;
        sb_d     = sb_q;
        ss_d     = ss_q;
        bto_d    = bto_q;
        vld_d    = vld_q;
        last_d   = last_q;
        rng_d    = rng_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (full_q != 2'b00) begin
                    state_d  = S_DRAIN;
                    rd_idx_d = '0;
                    ld_sb_d  = '0;
                    ld_ss_d  = '0;
                    case (full_q)
                        2'b01:   dbank_d = 1'b0;
                        2'b10:   dbank_d = 1'b1;
                        default: dbank_d = fptr_q;
                    endcase
                end
            end
            S_DRAIN: begin
                if (!vld_q || dout_ready) begin
                    if (rd_idx_q != LEN_A) begin
                        ch1_d    = rd_word[2*DATA_W-1:DATA_W];
                        ch2_d    = rd_word[DATA_W-1:0];
                        sb_d     = ld_sb_q;
                        ss_d     = ld_ss_q;
                        bto_d    = bt_q[dbank_q];
                        vld_d    = 1'b1;
                        last_d   = (rd_idx_q == LAST_A);
                        rd_idx_d = rd_idx_q + 10'd1;
                        if (ld_ss_q == 5'd17) begin
                            ld_ss_d = '0;
                            ld_sb_d = ld_sb_q + 5'd1;
                        end else begin
                            ld_ss_d = ld_ss_q + 5'd1;
                        end
                    end else begin
                        vld_d  = 1'b0;
                        last_d = 1'b0;
                    end
                end
                if (vld_q && dout_ready && last_q) begin
                    state_d         = S_IDLE;
                    full_d[dbank_q] = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (din_v) begin
            if (full_q[fptr_q]) begin
                ovf_d = 1'b1;
            end else begin
                if (cnt_q == '0) bt_d[fptr_q] = block_type_in;
                if (is_pos_in_x >= LEN_A || is_pos_in_y >= LEN_A)
                    rng_d = 1'b1;
                if (cnt_q == LAST_C) begin
                    cnt_d          = '0;
                    full_d[fptr_q] = 1'b1;
                    fptr_d         = !fptr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            fptr_q   <= 1'b0;
            cnt_q    <= '0;
            bt_q     <= '0;
            state_q  <= S_IDLE;
            dbank_q  <= 1'b0;
            rd_idx_q <= '0;
            ld_sb_q  <= '0;
            ld_ss_q  <= '0;
            ch1_q    <= '0;
            ch2_q    <= '0;
            sb_q     <= '0;
            ss_q     <= '0;
            bto_q    <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            rng_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            fptr_q   <= fptr_d;
            cnt_q    <= cnt_d;
            bt_q     <= bt_d;
            state_q  <= state_d;
            dbank_q  <= dbank_d;
            rd_idx_q <= rd_idx_d;
            ld_sb_q  <= ld_sb_d;
            ld_ss_q  <= ld_ss_d;
            ch1_q    <= ch1_d;
            ch2_q    <= ch2_d;
            sb_q     <= sb_d;
            ss_q     <= ss_d;
            bto_q    <= bto_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            rng_q    <= rng_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ch1_out        = ch1_q;
    assign ch2_out        = ch2_q;
    assign sb_out         = sb_q;
    assign ss_out         = ss_q;
    assign block_type_out = bto_q;
    assign dout_v         = vld_q;
    assign gr_last        = last_q;
    assign err_range      = rng_q;
    assign err_overflow   = ovf_q;

endmodule

// File: doc/aa_reorder_buffer.md
AA_REORDER_BUFFER -- requirements
Module: aa_reorder_buffer

Interface
REQ-001 Parameter DATA_W, 32, width of one channel sample (signed Q2_30).
REQ-002 Parameter GR_LEN, 576, samples per channel per granule.
REQ-003 Parameter BEATS, 288, input pair-beats per granule (GR_LEN/2).
REQ-004 Reset rst is synchronous and active-high; clock is clk.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ch1_in_x, ch1_in_y, ch2_in_x, ch2_in_y  in  DATA_W each  antialiased sample pair per channel.
REQ-008 is_pos_in_x, is_pos_in_y  in  10 each  granule sample index for x and y data.
REQ-009 din_v  in  1  input pair beat valid; no backpressure on input.
REQ-010 block_type_in  in  2x2  per-channel block_type, sampled on first beat of a granule.
REQ-011 ch1_out, ch2_out  out  DATA_W each  reordered sample per channel.
REQ-012 sb_out  out  5  subband index 0..31; ss_out  out  5  sample-in-subband 0..17.
REQ-013 block_type_out  out  2x2  block_type latched for the granule being drained.
REQ-014 dout_v  out  1  output valid; dout_ready  in  1  downstream (IMDCT) ready.
REQ-015 gr_last  out  1  high with the beat sb_out=31, ss_out=17.
REQ-016 err_range, err_overflow  out  1 each  sticky error flags.

Function
REQ-017 Two banks (A, B), each GR_LEN x 2*DATA_W; one bank filling while the other drains.
REQ-018 Fill: each din_v beat writes {ch1_x,ch2_x} at is_pos_in_x and {ch1_y,ch2_y} at is_pos_in_y in the fill bank, same cycle.
REQ-019 is_pos_in_x == is_pos_in_y: y data wins.
REQ-020 Index >= GR_LEN: that write dropped, err_range set; beat still counted.
REQ-021 Fill beat counter 0..BEATS-1; on beat BEATS-1 the fill bank is marked full, counter wraps to 0, fill pointer toggles to the other bank.
REQ-022 din_v with both banks full: beat dropped, counter unchanged, err_overflow set.
REQ-023 Drain FSM: IDLE -> DRAIN when a full bank exists (oldest first, A before B on tie); DRAIN -> IDLE after the gr_last beat is accepted; drained bank then marked empty.
REQ-024 Drain order: address sb*18+ss, ss fastest, sb 0..31; sb_out/ss_out match the data presented.
REQ-025 Handshake: beat transfers when dout_v && dout_ready; while dout_v && !dout_ready all outputs held stable.
REQ-026 dout_v never deasserts without a transfer, except on rst.
REQ-027 Latency: first dout_v no later than 3 cycles after bank becomes full with FSM in IDLE (2-cycle BRAM read plus register).
REQ-028 Throughput: with dout_ready held high, one beat per cycle, 576 consecutive beats per granule, no bubbles.
REQ-029 Bank marked full and drained in the same cycle: fill may target the freed bank next cycle, never the same cycle.
REQ-030 block_type_in latched per bank on beat 0; block_type_out reflects the draining bank's copy.
REQ-031 Simultaneous final drain beat and final fill beat: both complete; the next granule's drain starts without an extra idle beyond REQ-027.

Reset
REQ-032 On rst: both banks empty, fill counter 0, fill pointer A, FSM IDLE, dout_v 0, gr_last 0, sb_out 0, ss_out 0, ch1_out/ch2_out 0, block_type_out 0, err flags 0.
REQ-033 rst mid-fill or mid-drain abandons the granule; bank contents are not cleared but are never output.
REQ-034 Error flags clear only on rst.

Verification
REQ-035 288 beats, is_pos_x=2k, is_pos_y=2k+1, data=index, dout_ready=1 -> 576 beats, ch1_out=sb*18+ss, dout_v within 3 cycles, gr_last on beat 575.
REQ-036 Same granule, dout_ready toggled 1010... -> same sequence, outputs stable while stalled, 576 transfers total.
REQ-037 Three granules back-to-back, dout_ready=0 -> granules 1,2 stored, granule 3 beats dropped, err_overflow=1; release ready -> granules 1 then 2 output intact.
REQ-038 Beat with is_pos_x=600 -> err_range=1, location 600 untouched, other samples correct.
REQ-039 is_pos_x=is_pos_y=5, x=0xAAAA, y=0x5555 -> index 5 outputs 0x5555.
REQ-040 rst asserted at drain beat 100 -> next cycle dout_v=0, all outputs 0; fresh granule then drains correctly from sb 0, ss 0.
